// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and opcode constants for the control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd7
    } ctrl_state_e;

    localparam int unsigned OP_LOAD      = 0;
    localparam int unsigned OP_STORE     = 1;
    localparam int unsigned OP_ALU_FIRST = 2;
    localparam int unsigned OP_ALU_LAST  = 11;
    localparam int unsigned OP_CMP       = 12;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_sel;
        logic is_alu_op;
        logic is_load_store;
        logic writes_reg;
    } ctrl_flags_t;

    localparam ctrl_flags_t C_FLAGS_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_sequencer_if
// Description : Handshake, decode and status bundle of the control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_sequencer_if #(
    parameter int OPCODE_W = 4
) ();
    logic                run;
    logic                inst_req;
    logic                inst_ack;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_req;
    logic                mem_ack;
    logic                mem_read;
    logic                mem_write;
    logic                is_alu_op;
    logic                is_load_store;
    logic                wb_sel;
    logic                alu_en;
    logic                reg_write;
    logic                retire;
    logic                busy;
    logic                err_timeout;
    logic                err_illegal;
    logic [2:0]          state_o;

    // master = the sequencer, which issues the memory requests
    modport master (
        input  run, inst_ack, opcode, mem_ack,
        output inst_req, mem_req, mem_read, mem_write, is_alu_op, is_load_store,
               wb_sel, alu_en, reg_write, retire, busy, err_timeout, err_illegal,
               state_o
    );

    modport slave (
        output run, inst_ack, opcode, mem_ack,
        input  inst_req, mem_req, mem_read, mem_write, is_alu_op, is_load_store,
               wb_sel, alu_en, reg_write, retire, busy, err_timeout, err_illegal,
               state_o
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_opcode_decode
// Description : Combinational opcode to control-flag decode with illegal bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_opcode_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  wire logic [OPCODE_W-1:0] opcode_i,
    output ctrl_flags_t              flags_o,
    output logic                     illegal_o
);

    logic [31:0] w_op;
    assign w_op = 32'(opcode_i);

    always_comb begin
        flags_o   = C_FLAGS_NONE;
        illegal_o = 1'b0;
        if (w_op == OP_LOAD) begin
            flags_o.is_load_store = 1'b1;
            flags_o.mem_read      = 1'b1;
            flags_o.wb_sel        = 1'b1;
            flags_o.writes_reg    = 1'b1;
        end else if (w_op == OP_STORE) begin
            flags_o.is_load_store = 1'b1;
            flags_o.mem_write     = 1'b1;
        end else if ((w_op >= OP_ALU_FIRST) && (w_op <= OP_ALU_LAST)) begin
            flags_o.is_alu_op  = 1'b1;
            flags_o.writes_reg = 1'b1;
        end else if (w_op == OP_CMP) begin
            flags_o.is_alu_op = 1'b1;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
//               ack watchdog. Define CTRL_ILLEGAL_TRAP_EN to trap illegal
//               opcodes into ERROR instead of executing them as NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ctrl_sequencer_if.master  bus
);

    localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    ctrl_state_e         state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    ctrl_flags_t         flags_q, flags_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_illegal_q, err_illegal_d;

    ctrl_flags_t         w_dec_flags;
    logic                w_dec_illegal;
    logic [CNT_W-1:0]    w_wait_inc;

    ctrl_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode_i  (opcode_q),
        .flags_o   (w_dec_flags),
        .illegal_o (w_dec_illegal)
    );

    assign w_wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        flags_d       = flags_q;
        wait_d        = wait_q;
        err_timeout_d = err_timeout_q;
        err_illegal_d = err_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.inst_ack) begin
                    opcode_d = bus.opcode;
                    state_d  = ST_DECODE;
                end else begin
                    wait_d = w_wait_inc;
                    if (w_wait_inc == C_TIMEOUT) begin
                        state_d       = ST_ERROR;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                flags_d = w_dec_flags;
                if (w_dec_illegal) begin
                    state_d       = ST_ERROR;
                    err_illegal_d = 1'b1;
                end
`else
                // An illegal opcode carries no class flags and so runs as a NOP
                flags_d = w_dec_illegal ? C_FLAGS_NONE : w_dec_flags;
`endif
            end
            ST_EXEC: begin
                state_d = flags_q.is_load_store ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    state_d = ST_WB;
                end else begin
                    wait_d = w_wait_inc;
                    if (w_wait_inc == C_TIMEOUT) begin
                        state_d       = ST_ERROR;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d = bus.run ? ST_FETCH : ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)))
            wait_d = '0;
        if ((state_d == ST_IDLE) || (state_d == ST_FETCH) || (state_d == ST_ERROR))
            flags_d = C_FLAGS_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            opcode_q      <= '0;
            flags_q       <= C_FLAGS_NONE;
            wait_q        <= '0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            flags_q       <= flags_d;
            wait_q        <= wait_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign bus.inst_req      = (state_q == ST_FETCH);
    assign bus.mem_req       = (state_q == ST_MEM);
    assign bus.mem_read      = (state_q == ST_MEM) && flags_q.mem_read;
    assign bus.mem_write     = (state_q == ST_MEM) && flags_q.mem_write;
    assign bus.is_alu_op     = flags_q.is_alu_op;
    assign bus.is_load_store = flags_q.is_load_store;
    assign bus.wb_sel        = flags_q.wb_sel;
    assign bus.alu_en        = (state_q == ST_EXEC) && flags_q.is_alu_op;
    assign bus.reg_write     = (state_q == ST_WB) && flags_q.writes_reg;
    assign bus.retire        = (state_q == ST_WB);
    assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign bus.err_timeout   = err_timeout_q;
    assign bus.err_illegal   = err_illegal_q;
    assign bus.state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_sequencer
// Description : Self-checking bench for ctrl_sequencer with a cycle-level
//               reference model of the instruction phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

    localparam int OW = 4;
    localparam int TO = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    ctrl_sequencer_if #(.OPCODE_W(OW)) bus ();

    ctrl_sequencer #(.OPCODE_W(OW), .TIMEOUT_CYC(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] obs_v;
    assign obs_v = {bus.inst_req, bus.mem_req, bus.mem_read, bus.mem_write,
                    bus.is_alu_op, bus.is_load_store, bus.wb_sel, bus.alu_en,
                    bus.reg_write, bus.retire, bus.busy, bus.err_timeout,
                    bus.err_illegal, bus.state_o};

    // Expected outputs for a phase (state number) of an instruction with opcode op
    function automatic logic [15:0] mk(input int st, input int op, input bit et, input bit ei);
        bit ls, alu, wr, fl;
        ls  = (op == 0) || (op == 1);
        alu = (op >= 2) && (op <= 12);
        wr  = (op == 0) || ((op >= 2) && (op <= 11));
        fl  = (st >= 3) && (st <= 5);
        mk = {st == 1, st == 4, (st == 4) && (op == 0), (st == 4) && (op == 1),
              fl && alu, fl && ls, fl && (op == 0), (st == 3) && alu,
              (st == 5) && wr, st == 5, (st >= 1) && (st <= 5), et, ei, 3'(st)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        n_total++;
        assert (obs_v === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs_v, exp);
        end
    endtask

    task automatic expect_error(input bit et, input bit ei);
        for (int i = 0; i < 3; i++) begin
            bus.run      = 1'($urandom);
            bus.inst_ack = 1'($urandom);
            bus.mem_ack  = 1'($urandom);
            chk("error_hold", mk(7, 0, et, ei));
            step();
        end
        bus.inst_ack = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    // Drives one instruction starting in its first FETCH cycle; fd/md are the
    // ack cycle indices, and a value >= TO means the ack never comes.
    task automatic do_instr(input int op, input int fd, input int md,
                            input bit run_after, output bit errd);
        errd = 1'b0;
        for (int i = 0; i < TO; i++) begin
            bus.run      = 1'($urandom);
            bus.mem_ack  = 1'($urandom);
            bus.inst_ack = (i == fd);
            bus.opcode   = (i == fd) ? OW'(op) : OW'($urandom);
            chk($sformatf("fetch op%0d", op), mk(1, op, 0, 0));
            step();
            if (i == fd) break;
        end
        bus.inst_ack = 1'b0;
        if (fd >= TO) begin
            expect_error(1'b1, 1'b0);
            errd = 1'b1;
            return;
        end
        bus.mem_ack = 1'($urandom);
        chk($sformatf("decode op%0d", op), mk(2, op, 0, 0));
        step();
        if (TRAP && (op >= 13)) begin
            expect_error(1'b0, 1'b1);
            errd = 1'b1;
            return;
        end
        bus.inst_ack = 1'($urandom);
        chk($sformatf("exec op%0d", op), mk(3, op, 0, 0));
        step();
        bus.mem_ack = 1'b0;
        if (op <= 1) begin
            for (int i = 0; i < TO; i++) begin
                bus.inst_ack = 1'($urandom);
                bus.mem_ack  = (i == md);
                chk($sformatf("mem op%0d", op), mk(4, op, 0, 0));
                step();
                if (i == md) break;
            end
            bus.mem_ack = 1'b0;
            if (md >= TO) begin
                expect_error(1'b1, 1'b0);
                errd = 1'b1;
                return;
            end
        end
        bus.run = run_after;
        chk($sformatf("wb op%0d", op), mk(5, op, 0, 0));
        step();
        bus.inst_ack = 1'b0;
    endtask

    // Returns to the first FETCH cycle, through a reset pulse if stuck in ERROR
    task automatic resume(input bit from_error);
        bus.run = 1'b0;
        if (from_error) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        chk("idle", mk(0, 0, 0, 0));
        step();
        chk("idle_hold", mk(0, 0, 0, 0));
        bus.run = 1'b1;
        step();
    endtask

    initial begin
        bit errd;
        int op, fd, md;
        bit ra;

        rst_n        = 1'b0;
        bus.run      = 1'b1;
        bus.inst_ack = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.opcode   = '0;
        repeat (3) step();
        chk("reset", mk(0, 0, 0, 0));
        bus.inst_ack = 1'b0;
        bus.mem_ack  = 1'b0;
        rst_n        = 1'b1;
        chk("idle_run", mk(0, 0, 0, 0));
        step();

        do_instr(3, 0, 0, 1'b1, errd);       // ALU: 4-cycle instruction
        do_instr(0, 0, 3, 1'b1, errd);       // LOAD with 3 wait cycles: 8 cycles
        do_instr(1, 1, 0, 1'b1, errd);       // STORE
        do_instr(12, 0, 0, 1'b1, errd);      // CMP
        do_instr(11, 2, 0, 1'b0, errd);
        resume(1'b0);

        // Reset in the middle of a LOAD's memory wait
        bus.inst_ack = 1'b1;
        bus.opcode   = OW'(0);
        chk("mid_fetch", mk(1, 0, 0, 0));
        step();
        bus.inst_ack = 1'b0;
        chk("mid_decode", mk(2, 0, 0, 0));
        step();
        chk("mid_exec", mk(3, 0, 0, 0));
        step();
        chk("mid_mem0", mk(4, 0, 0, 0));
        step();
        chk("mid_mem1", mk(4, 0, 0, 0));
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        bus.run = 1'b0;
        chk("rst_mid_mem", mk(0, 0, 0, 0));
        bus.run = 1'b1;
        step();

        do_instr(3, TO, 0, 1'b1, errd);      // fetch timeout
        resume(errd);
        do_instr(3, TO - 1, 0, 1'b1, errd);  // ack on the limit cycle wins
        do_instr(0, 0, TO, 1'b1, errd);      // memory timeout
        resume(errd);
        do_instr(1, 0, TO - 1, 1'b1, errd);
        do_instr(14, 0, 0, 1'b1, errd);      // illegal opcode
        if (errd) resume(1'b1);

        for (int k = 0; k < 24; k++) begin
            op = TRAP ? $urandom_range(0, 12) : $urandom_range(0, 15);
            fd = $urandom_range(0, TO - 1);
            md = $urandom_range(0, TO - 1);
            ra = ($urandom_range(0, 3) != 0);
            do_instr(op, fd, md, ra, errd);
            if (errd || !ra) resume(errd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle, clocked control sequencer for the 16-bit RISC core; successor to the edge-triggered opcode decoder. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK with req/ack handshakes to instruction and data memory. It decodes a parametrised opcode into registered datapath control flags and adds a wait-timeout watchdog, run/idle control, a retire strobe and optional illegal-opcode trapping.

## Interface
- OPCODE_W, 4: opcode width; values ≥ 13 are illegal.
- TIMEOUT_CYC, 16: maximum wait cycles for any ack; must be ≥ 1.
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  level; permits leaving IDLE and continuing after WB
- inst_req  out  1  instruction fetch request
- inst_ack  in  1  fetch complete; opcode valid this cycle
- opcode  in  OPCODE_W  opcode of fetched instruction, sampled on inst_ack
- mem_req  out  1  data memory request
- mem_ack  in  1  data access complete
- mem_read / mem_write  out  1  access direction, valid while mem_req
- is_alu_op / is_load_store  out  1  registered class flags of the current instruction
- wb_sel  out  1  0 = ALU result, 1 = memory data
- alu_en  out  1  ALU evaluate strobe
- reg_write  out  1  register-file write strobe
- retire  out  1  one-cycle pulse when an instruction completes
- busy  out  1  high in any state except IDLE and ERROR
- err_timeout / err_illegal  out  1  sticky error flags
- state_o  out  3  current state encoding, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=7.
- Reset: state IDLE; every output 0; wait counter 0; latched flags 0. Reset overrides any state, including mid-handshake.
- IDLE: go to FETCH when run=1.
- FETCH: inst_req=1. On inst_ack, latch opcode and go to DECODE.
- DECODE: one cycle. Register the class flags:
  - 0 LOAD: is_load_store=1, mem_read=1, wb_sel=1, writes register.
  - 1 STORE: is_load_store=1, mem_write=1, no register write.
  - 2–11 ALU: is_alu_op=1, wb_sel=0, writes register.
  - 12 CMP/NOP: is_alu_op=1, no register write.
- EXEC: one cycle; alu_en=1 for opcodes 2–12. Next state is MEM for LOAD/STORE, WB otherwise.
- MEM: mem_req=1 with mem_read/mem_write held. On mem_ack, go to WB.
- WB: one cycle; reg_write=1 for writing opcodes; retire=1. Go to FETCH if run=1, else IDLE. The class flags clear on entering IDLE or FETCH.
- Watchdog:
  - The counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - If the counter reaches TIMEOUT_CYC with no ack, go to ERROR and set err_timeout=1.
  - An ack arriving in the same cycle the limit is reached wins; no error.
- ERROR: all strobes and requests 0, busy=0. The state is held until rst_n=0.
- run deasserting mid-instruction does not abort it; it is honoured only in WB and IDLE.
- An ack outside the corresponding request state is ignored.

## Timing
- All outputs are registered or a pure decode of registered state and flags; no input-to-output combinational path.
- inst_req rises the cycle after entering FETCH is decided; i.e. the first FETCH cycle shows inst_req=1.
- Minimum latency, ack on the first request cycle:
  - ALU/CMP: 4 cycles, FETCH→DECODE→EXEC→WB.
  - LOAD/STORE: 5 cycles.
- Back-to-back with run=1: retire every 4 cycles for ALU streams.
- Each wait cycle without ack adds one cycle.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE goes to ERROR and sets err_illegal=1; no retire.
- CTRL_ILLEGAL_TRAP_EN undefined: an illegal opcode is executed as a NOP. It goes DECODE→EXEC→WB with no alu_en and no reg_write, and retire=1. err_illegal is tied 0.

## Structure
- Shared package ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_LOAD=0, OP_STORE=1, OP_ALU_FIRST=2, OP_ALU_LAST=11, OP_CMP=12;
  - a packed ctrl_flags_t struct with mem_read, mem_write, wb_sel, is_alu_op, is_load_store, writes_reg.
- One sub-module, ctrl_opcode_decode: combinational opcode → ctrl_flags_t plus illegal bit, registered by the sequencer in DECODE.

## Test plan
- Reset mid-MEM: rst_n=0 for 1 cycle during a LOAD wait → next cycle state_o=0, all outputs 0.
- run=1, opcode=3, inst_ack on first FETCH cycle:
  - alu_en in cycle 3 and reg_write=1, wb_sel=0, retire=1 in cycle 4;
  - FETCH again in cycle 5.
- LOAD with mem_ack delayed 3 cycles: mem_req high 4 cycles, mem_read=1, then WB with wb_sel=1, reg_write=1; total 8 cycles.
- STORE: mem_write=1 during MEM, reg_write=0 in WB, retire=1.
- TIMEOUT_CYC=4, inst_ack never asserted:
  - ERROR entered, err_timeout=1, busy=0, held until reset;
  - repeat with inst_ack on the 4th wait cycle → no error.
- opcode=14: with CTRL_ILLEGAL_TRAP_EN → ERROR, err_illegal=1; without → retire=1, no reg_write, no alu_en.
